// File: rtl/als_spi_responder_pkg.sv
// Shared constants, state encoding and LFSR step for the ALS SPI responder.
package als_resp_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int LEAD_ZEROS  = 4;
  localparam int DATA_W      = 8;
  localparam int TRAIL_ZEROS = 4;

  localparam logic [DATA_W-1:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form taps bits 7,5,4,3
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  typedef enum logic [1:0] {
    ARM   = ST_ARM,
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_e;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] cur);
    return {cur[DATA_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/als_spi_responder_sync.sv
// Multi-flop synchronizer with rise/fall detection; all flops reset to the idle-high level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/als_spi_responder.sv
// SPI responder emulating the ambient-light ADC: serves {4'b0, sample, 4'b0} frames on sdo.
// Optional feature macro: ALS_RESP_LFSR_EN (stale samples replaced by an LFSR pattern).
import als_resp_pkg::*;

module als_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ncs,
  input  logic       sck,
  output logic       sdo,
  output logic       sdo_oe,
  input  logic [7:0] sample_data,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [1:0] ARM_WAIT = 2'(SYNC_STAGES);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sck_s_unused, sck_rise_unused, sck_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ncs),
    .level (ncs_s),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck),
    .level (sck_s_unused),
    .rise  (sck_rise_unused),
    .fall  (sck_fall)
  );

  logic [1:0]            state_q, state_d;
  logic [1:0]            arm_cnt_q, arm_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  fresh_q, fresh_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     load_data;
`ifdef ALS_RESP_LFSR_EN
  logic [DATA_W-1:0]     lfsr_q, lfsr_d;
`endif

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    fresh_d   = fresh_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef ALS_RESP_LFSR_EN
    lfsr_d    = lfsr_q;
    load_data = sample_valid ? sample_data : (fresh_q ? hold_q : lfsr_q);
`else
    load_data = sample_valid ? sample_data : hold_q;
`endif

    if (sample_valid) begin
      hold_d  = sample_data;
      fresh_d = 1'b1;
    end

    case (state_q)
      // The synchronizer holds its reset value for a few cycles, so wait for it
      // to carry real pin data before trusting a high ncs.
      ST_ARM: begin
        if (arm_cnt_q != ARM_WAIT) begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end else if (ncs_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ncs_fall) begin
          shreg_d   = {{LEAD_ZEROS{1'b0}}, load_data, {TRAIL_ZEROS{1'b0}}};
          bit_cnt_d = '0;
          fresh_d   = 1'b0;
          state_d   = ST_SHIFT;
`ifdef ALS_RESP_LFSR_EN
          lfsr_d    = lfsr_next(lfsr_q);
`endif
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          done_d  = (bit_cnt_q >= 5'd15);
          err_d   = (bit_cnt_q < 5'd15);
          state_d = ST_IDLE;
        end else if (sck_fall) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt_q != 5'(FRAME_BITS)) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ARM;
      arm_cnt_q <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      fresh_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ALS_RESP_LFSR_EN
      lfsr_q    <= LFSR_SEED;
`endif
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      fresh_q   <= fresh_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef ALS_RESP_LFSR_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign sdo_oe       = (state_q == ST_SHIFT);
  assign sdo          = (state_q == ST_SHIFT) & shreg_q[FRAME_BITS-1];
  assign sample_ready = 1'b1;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule

// File: doc/als_spi_responder.md
# als_spi_responder

Synthesizable SPI responder that emulates the ambient-light-sensor ADC on the far end of the `lightpwm` SPI read link. It lets the `lightpwm` master run in on-board loopback and self-test without the physical sensor. It accepts 8-bit light samples from fabric and serves them as 16-bit frames on `sdo`: 4 leading zeros, 8 data bits MSB first, 4 trailing zeros. Frame timing is driven by the master's `ncs`/`sck`, which are oversampled in the `clk` domain.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `ncs` and `sck`; legal range 2–3.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ncs` in 1: SPI chip select from master, active low, asynchronous to `clk`.
- `sck` in 1: SPI clock from master, idles high, asynchronous to `clk`.
- `sdo` out 1: serial data to master.
- `sdo_oe` out 1: high while a frame is active; board-level tristate enable.
- `sample_data` in 8: next light sample.
- `sample_valid` in 1: `sample_data` is valid this cycle.
- `sample_ready` out 1: constant 1; a sample is accepted every cycle `sample_valid` is high.
- `frame_done` out 1: one-cycle pulse when a complete frame ends.
- `frame_err` out 1: one-cycle pulse when `ncs` rises before the frame is complete.

## Operation
- `ncs_s` and `sck_s` are the synchronized inputs. Falling and rising edges are detected from the last synchronizer stage and a one-flop history.
- Hold register `hold[7:0]`: written with `sample_data` on every cycle `sample_valid` is high. A `fresh` flag is set on write and cleared at frame load.
- State machine:
  - ARM: entered after reset. Moves to IDLE once `ncs_s` is seen high. This prevents a spurious frame when `ncs` is low at reset release.
  - IDLE: `sdo=0`, `sdo_oe=0`. On `ncs_s` falling:
    - load `shreg[15:0] = {4'b0, D, 4'b0}`;
    - D is `sample_data` if `sample_valid` is high in that same cycle (bypass), otherwise `hold`;
    - clear `bit_cnt` and go to SHIFT.
  - SHIFT: `sdo = shreg[15]`, `sdo_oe=1`.
    - On each `sck_s` falling edge: `shreg <= shreg << 1`, zero fill; `bit_cnt` increments and saturates at 16.
    - Extra falling edges beyond 16 shift out zeros.
    - `sck_s` rising edges are ignored.
    - On `ncs_s` rising: pulse `frame_done` if `bit_cnt >= 15`, else pulse `frame_err`; return to IDLE.
- If `ncs_s` rises and `sck_s` falls in the same cycle, `ncs_s` wins: no shift, frame ends.

## Timing
- Reset values: `sdo=0`, `sdo_oe=0`, `frame_done=0`, `frame_err=0`, `hold=8'h00`, `fresh=0`, `bit_cnt=0`, `shreg=0`, state ARM. Synchronizer flops reset to 1 (idle levels).
- Latency: a pin edge on `ncs` or `sck` changes `sdo` SYNC_STAGES+1 `clk` cycles later; that is 3 cycles at the default setting.
- The master must hold each `sck` phase for at least SYNC_STAGES+2 `clk` cycles.
- The first data bit is on `sdo` SYNC_STAGES+1 cycles after `ncs` falls. The master must not sample before that.
- Reset asserted mid-frame: the frame is abandoned with no `frame_done`/`frame_err` pulse, and the block restarts in ARM.
- `frame_done` and `frame_err` are registered, asserted in the cycle after the `ncs_s` rising detection, and never both high.

## Configuration
- `ALS_RESP_LFSR_EN` defined: an 8-bit Fibonacci LFSR runs with polynomial x^8+x^6+x^5+x^4+1 and seed `8'hA5` at reset.
  - It advances once per frame load.
  - At frame load with `fresh=0` and no bypass, D is the current LFSR value instead of `hold`.
- `ALS_RESP_LFSR_EN` undefined: no LFSR; a stale `hold` is re-sent unchanged.

## Structure
- Package `als_resp_pkg`:
  - constants `FRAME_BITS=16`, `LEAD_ZEROS=4`, `DATA_W=8`, `TRAIL_ZEROS=4`, `LFSR_SEED=8'hA5`, `LFSR_TAPS`;
  - state enum `{ARM, IDLE, SHIFT}`.
- Sub-module `spi_sync_edge`: SYNC_STAGES-deep synchronizer plus rise/fall detector with reset value 1. It is instantiated twice, once for `ncs` and once for `sck`.
- The top level holds the FSM, shift register, hold register, counters and the optional LFSR.

## Test plan
- Load `sample_data=8'hB6` with one `sample_valid` pulse, then run a 16-falling-edge frame with a 6-cycle `sck` half period. Master captures 16'h0B60; exactly one `frame_done`; `sdo_oe` high only inside the frame.
- Raise `ncs` after 7 falling edges. One `frame_err` pulse, no `frame_done`; the next full frame still returns 16'h0B60.
- Pulse `sample_valid` with 8'h3C in the same cycle the synchronized `ncs` falls while `hold` is 8'hB6. The frame returns 16'h03C0, proving the bypass.
- Hold `ncs` low through reset release. No frame starts, `sdo_oe` stays 0. After `ncs` goes high then low, a normal frame runs.
- Assert `rst_n=0` at edge 9 of a frame. All outputs are at reset values the next cycle, with no pulses. After reset, a frame returns 16'h0000 (`hold` reset to 0).
- With `ALS_RESP_LFSR_EN` defined and no samples loaded, run back-to-back frames. Data bits follow the LFSR sequence from 8'hA5. Then write 8'h11: the next frame returns 16'h0110, and the one after resumes the LFSR sequence.
